// File: rtl/owt_rx_ctrl.sv
`timescale 1ns/1ps
// owt_rx_ctrl: OWT receive frame sequencer; optional parity symbol/check via OWT_RX_PARITY_EN
module owt_rx_ctrl #(
    parameter int CNT_W    = 10,
    parameter int FRM_W    = 8,
    parameter int SYNC_NUM = 4,
    parameter int TMO_CYC  = 16,
    parameter int TMO_W    = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_sym_vld,
    input  logic             i_sym_data,
    input  logic [CNT_W-1:0] i_sync_dn_th,
    input  logic [CNT_W-1:0] i_sync_up_th,
    input  logic [CNT_W-1:0] i_data_dn_th,
    input  logic [CNT_W-1:0] i_data_up_th,
    output logic [CNT_W-1:0] o_dn_th,
    output logic [CNT_W-1:0] o_up_th,
    output logic             o_busy,
    output logic             o_frm_vld,
    output logic [FRM_W-1:0] o_frm_data,
    output logic             o_frm_err,
    output logic             o_tmo
);
    localparam int SC_W = $clog2(SYNC_NUM + 1);
    localparam int BC_W = $clog2(FRM_W + 1);
`ifdef OWT_RX_PARITY_EN
    typedef enum logic [1:0] {IDLE, SYNC, DATA, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, SYNC, DATA} state_t;
`endif
    state_t           state_q, state_d;
    logic [SC_W-1:0]  sync_cnt_q, sync_cnt_d;
    logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [FRM_W-1:0] shreg_q, shreg_d;
    logic [FRM_W-1:0] frm_data_q, frm_data_d;
    logic             frm_vld_q, frm_vld_d;
    logic             frm_err_q, frm_err_d;
    logic             tmo_q, tmo_d;
    logic             sync_ok, tmo_hit, last_bit, in_frm;

    assign sync_ok  = sync_cnt_q >= SC_W'(SYNC_NUM);
    assign tmo_hit  = tmo_cnt_q == TMO_W'(TMO_CYC - 1);
    assign last_bit = bit_cnt_q == BC_W'(FRM_W - 1);

    // state and datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            sync_cnt_q <= '0;
            bit_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
            shreg_q    <= '0;
            frm_data_q <= '0;
            frm_vld_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_cnt_q <= sync_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            shreg_q    <= shreg_d;
            frm_data_q <= frm_data_d;
            frm_vld_q  <= frm_vld_d;
            frm_err_q  <= frm_err_d;
            tmo_q      <= tmo_d;
        end
    end

    // next state: disable beats everything, an arriving symbol beats timeout
    always_comb begin
        state_d    = state_q;
        sync_cnt_d = sync_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        shreg_d    = shreg_q;
        frm_data_d = frm_data_q;
        frm_err_d  = frm_err_q;
        frm_vld_d  = 1'b0;
        tmo_d      = 1'b0;
        if (state_q != IDLE && !i_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (i_en) begin
                    state_d    = SYNC;
                    sync_cnt_d = '0;
                end
                SYNC: if (i_sym_vld) begin
                    if (i_sym_data) begin
                        sync_cnt_d = sync_ok ? sync_cnt_q : sync_cnt_q + 1'b1;
                    end else if (sync_ok) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                        shreg_d   = '0;
                        tmo_cnt_d = '0;
                    end else begin
                        sync_cnt_d = '0;
                    end
                end
                DATA: if (i_sym_vld) begin
                    shreg_d   = {shreg_q[FRM_W-2:0], i_sym_data};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    tmo_cnt_d = '0;
                    if (last_bit) begin
`ifdef OWT_RX_PARITY_EN
                        state_d = PAR;
`else
                        state_d    = SYNC;
                        sync_cnt_d = '0;
                        frm_vld_d  = 1'b1;
                        frm_data_d = shreg_d;
                        frm_err_d  = 1'b0;
`endif
                    end
                end else if (tmo_hit) begin
                    state_d    = SYNC;
                    sync_cnt_d = '0;
                    tmo_d      = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`ifdef OWT_RX_PARITY_EN
                PAR: if (i_sym_vld) begin
                    state_d    = SYNC;
                    sync_cnt_d = '0;
                    tmo_cnt_d  = '0;
                    frm_vld_d  = 1'b1;
                    frm_data_d = shreg_q;
                    frm_err_d  = (^shreg_q) ^ i_sym_data;
                end else if (tmo_hit) begin
                    state_d    = SYNC;
                    sync_cnt_d = '0;
                    tmo_d      = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    // outputs: threshold set follows the registered phase
    always_comb begin
`ifdef OWT_RX_PARITY_EN
        in_frm = state_q == DATA || state_q == PAR;
`else
        in_frm = state_q == DATA;
`endif
        o_busy     = in_frm;
        o_dn_th    = in_frm ? i_data_dn_th : i_sync_dn_th;
        o_up_th    = in_frm ? i_data_up_th : i_sync_up_th;
        o_frm_vld  = frm_vld_q;
        o_frm_data = frm_data_q;
        o_frm_err  = frm_err_q;
        o_tmo      = tmo_q;
    end
endmodule

// File: tb/tb_owt_rx_ctrl.sv
`timescale 1ns/1ps
// tb_owt_rx_ctrl: scoreboard bench for owt_rx_ctrl (adapts to OWT_RX_PARITY_EN)
module tb_owt_rx_ctrl;
    localparam logic [9:0] S_DN = 10'd20, S_UP = 10'd40, D_DN = 10'd5, D_UP = 10'd12;
    logic       i_clk = 1'b0, i_rst = 1'b1, i_en = 1'b0, i_sym_vld = 1'b0, i_sym_data = 1'b0;
    logic [9:0] o_dn_th, o_up_th;
    logic       o_busy, o_frm_vld, o_frm_err, o_tmo;
    logic [7:0] o_frm_data;
    logic [7:0] last_data = 8'h00;
    logic [8:0] exp_q[$];
    int chk_cnt = 0, pass_cnt = 0, frm_seen = 0, tmo_seen = 0;

    owt_rx_ctrl dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en),
        .i_sym_vld(i_sym_vld), .i_sym_data(i_sym_data),
        .i_sync_dn_th(S_DN), .i_sync_up_th(S_UP),
        .i_data_dn_th(D_DN), .i_data_up_th(D_UP),
        .o_dn_th(o_dn_th), .o_up_th(o_up_th), .o_busy(o_busy),
        .o_frm_vld(o_frm_vld), .o_frm_data(o_frm_data),
        .o_frm_err(o_frm_err), .o_tmo(o_tmo)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_frm_vld === 1'b1) frm_seen++;
        if (o_tmo === 1'b1) tmo_seen++;
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge i_clk); #1; end
    endtask

    task automatic send_sym(input logic b);
        i_sym_vld = 1'b1;
        i_sym_data = b;
        tick(1);
        i_sym_vld = 1'b0;
    endtask

    task automatic start_frame();
        repeat (4) send_sym(1'b1);
        chk_cnt++;
        if ({o_dn_th, o_up_th} !== {S_DN, S_UP}) $display("FAIL th_sync: got %0d/%0d want %0d/%0d", o_dn_th, o_up_th, S_DN, S_UP);
        else pass_cnt++;
        send_sym(1'b0);
        chk_cnt++;
        if ({o_busy, o_dn_th, o_up_th} !== {1'b1, D_DN, D_UP}) $display("FAIL th_data: got busy=%b %0d/%0d want busy=1 %0d/%0d", o_busy, o_dn_th, o_up_th, D_DN, D_UP);
        else pass_cnt++;
    endtask

    task automatic expect_frame();
        logic [8:0] e;
        e = exp_q.size() > 0 ? exp_q.pop_front() : 9'h1ff;
        chk_cnt++;
        if (o_frm_vld !== 1'b1) $display("FAIL frm_vld_latency: got %b want 1", o_frm_vld);
        else pass_cnt++;
        chk_cnt++;
        if ({o_frm_data, o_frm_err} !== e) $display("FAIL frm_word: got %h err=%b want %h err=%b", o_frm_data, o_frm_err, e[8:1], e[0]);
        else pass_cnt++;
        last_data = e[8:1];
        tick(1);
        chk_cnt++;
        if (o_frm_vld !== 1'b0) $display("FAIL frm_vld_pulse: got %b want 0", o_frm_vld);
        else pass_cnt++;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad);
        start_frame();
`ifdef OWT_RX_PARITY_EN
        exp_q.push_back({d, bad});
`else
        exp_q.push_back({d, 1'b0});
`endif
        for (int i = 7; i >= 0; i--) send_sym(d[i]);
`ifdef OWT_RX_PARITY_EN
        send_sym(^d ^ bad);
`endif
        expect_frame();
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        tick(3);
        i_rst = 1'b0;
        chk_cnt++;
        if ({o_frm_vld, o_frm_data, o_frm_err, o_tmo, o_busy} !== 12'h0) $display("FAIL reset_out: got vld=%b data=%h err=%b tmo=%b busy=%b want all 0", o_frm_vld, o_frm_data, o_frm_err, o_tmo, o_busy);
        else pass_cnt++;
        chk_cnt++;
        if ({o_dn_th, o_up_th} !== {S_DN, S_UP}) $display("FAIL reset_th: got %0d/%0d want %0d/%0d", o_dn_th, o_up_th, S_DN, S_UP);
        else pass_cnt++;
    endtask

    task automatic test_idle_ignore();
        int f0 = frm_seen;
        repeat (4) send_sym(1'b1);
        send_sym(1'b0);
        repeat (8) send_sym(1'b1);
        tick(1);
        chk_cnt++;
        if (o_busy !== 1'b0 || frm_seen != f0) $display("FAIL idle_ignore: got busy=%b frames=%0d want busy=0 frames=0", o_busy, frm_seen - f0);
        else pass_cnt++;
        i_en = 1'b1;
        tick(1);
    endtask

    task automatic test_basic();
        send_frame(8'hA5, 1'b0);
    endtask

    task automatic test_parity_err();
`ifdef OWT_RX_PARITY_EN
        send_frame(8'hA5, 1'b1);
`endif
    endtask

    task automatic test_short_preamble();
        int f0 = frm_seen;
        repeat (3) send_sym(1'b1);
        send_sym(1'b0);
        chk_cnt++;
        if (o_busy !== 1'b0) $display("FAIL short_pre_busy: got %b want 0", o_busy);
        else pass_cnt++;
        send_frame(8'h3C, 1'b0);
        chk_cnt++;
        if (frm_seen - f0 != 1) $display("FAIL short_pre_count: got %0d want 1", frm_seen - f0);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        int f0 = frm_seen, t0 = tmo_seen;
        start_frame();
        send_sym(1'b1); send_sym(1'b0); send_sym(1'b1);
        tick(15);
        chk_cnt++;
        if ({o_tmo, o_busy} !== 2'b01) $display("FAIL tmo_early: got tmo=%b busy=%b want tmo=0 busy=1", o_tmo, o_busy);
        else pass_cnt++;
        tick(1);
        chk_cnt++;
        if ({o_tmo, o_busy, o_dn_th} !== {2'b10, S_DN}) $display("FAIL tmo_fire: got tmo=%b busy=%b dn=%0d want tmo=1 busy=0 dn=%0d", o_tmo, o_busy, o_dn_th, S_DN);
        else pass_cnt++;
        tick(1);
        chk_cnt++;
        if (o_tmo !== 1'b0 || tmo_seen - t0 != 1 || frm_seen != f0) $display("FAIL tmo_once: got tmo=%b pulses=%0d frames=%0d want 0/1/0", o_tmo, tmo_seen - t0, frm_seen - f0);
        else pass_cnt++;
        send_frame(8'h5A, 1'b0);
    endtask

    task automatic test_timeout_race();
        logic [7:0] d = 8'hC3;
        int t0 = tmo_seen;
        start_frame();
`ifdef OWT_RX_PARITY_EN
        exp_q.push_back({d, 1'b0});
`else
        exp_q.push_back({d, 1'b0});
`endif
        for (int i = 7; i >= 5; i--) send_sym(d[i]);
        tick(15);
        send_sym(d[4]);
        chk_cnt++;
        if ({o_tmo, o_busy} !== 2'b01) $display("FAIL race_accept: got tmo=%b busy=%b want tmo=0 busy=1", o_tmo, o_busy);
        else pass_cnt++;
        for (int i = 3; i >= 0; i--) send_sym(d[i]);
`ifdef OWT_RX_PARITY_EN
        send_sym(^d);
`endif
        expect_frame();
        chk_cnt++;
        if (tmo_seen != t0) $display("FAIL race_no_tmo: got %0d pulses want 0", tmo_seen - t0);
        else pass_cnt++;
    endtask

    task automatic test_disable();
        int f0 = frm_seen, t0 = tmo_seen;
        start_frame();
        repeat (7) send_sym(1'b1);
        i_en = 1'b0;
        send_sym(1'b1);
        chk_cnt++;
        if ({o_busy, o_frm_vld, o_dn_th, o_up_th} !== {2'b00, S_DN, S_UP}) $display("FAIL dis_abort: got busy=%b vld=%b th=%0d/%0d want 0/0 %0d/%0d", o_busy, o_frm_vld, o_dn_th, o_up_th, S_DN, S_UP);
        else pass_cnt++;
        chk_cnt++;
        if (o_frm_data !== last_data) $display("FAIL dis_hold: got %h want %h", o_frm_data, last_data);
        else pass_cnt++;
        tick(20);
        chk_cnt++;
        if (frm_seen != f0 || tmo_seen != t0) $display("FAIL dis_quiet: got frames=%0d tmo=%0d want 0/0", frm_seen - f0, tmo_seen - t0);
        else pass_cnt++;
        i_en = 1'b1;
        tick(1);
    endtask

    task automatic test_back_to_back();
        send_frame(8'h00, 1'b0);
        send_frame(8'hFF, 1'b0);
        send_frame(8'h81, 1'b0);
        chk_cnt++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        else pass_cnt++;
    endtask

    initial begin
        tick(1);
        test_reset();
        test_idle_ignore();
        test_basic();
        test_parity_err();
        test_short_preamble();
        test_timeout();
        test_timeout_race();
        test_disable();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
